regfile_writeback: RTL and testbench

- Write-port master for the 32x32 MIPS register file. The register file writes on posedge Clk when RegWrite=1; its reads occur on negedge.
- Merges two result sources onto the single write port:
  - ALU results: single-cycle, no backpressure.
  - Load/multi-cycle results: buffered in a FIFO with ready/valid handshake.
- Drops writes to $0 and provides a starvation guard and a pending-write hazard query for the decode stage.

---
 rtl/regfile_writeback_if.sv | 47 ++++
 rtl/regfile_writeback.sv | 146 ++++++++++++++
 tb/tb_regfile_writeback.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_writeback_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback_if
// Brief    : ALU/load result, hazard-query and register-file write-port bundle
// Revision : 1.0
// ============================================================================
interface regfile_writeback_if;
    logic        alu_valid;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        alu_stall;

    logic        mem_valid;
    logic [4:0]  mem_reg;
    logic [31:0] mem_data;
    logic        mem_ready;

    logic [4:0]  query_reg;
    logic        pend_hit;

    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        err;

    // master: the write-back block that owns the register-file write port
    modport master (
        input  alu_valid, alu_reg, alu_data,
        output alu_stall,
        input  mem_valid, mem_reg, mem_data,
        output mem_ready,
        input  query_reg,
        output pend_hit,
        output RegWrite, WriteRegister, WriteData, err
    );

    modport slave (
        output alu_valid, alu_reg, alu_data,
        input  alu_stall,
        output mem_valid, mem_reg, mem_data,
        input  mem_ready,
        output query_reg,
        input  pend_hit,
        input  RegWrite, WriteRegister, WriteData, err
    );
endinterface
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback
// Brief    : Merges ALU and queued load results onto the register-file write port
// Revision : 1.0
// ============================================================================
module regfile_writeback #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  wire logic           Clk,
    input  wire logic           Rst,
    regfile_writeback_if.master bus
);

    localparam int c_PTR_W    = $clog2(DEPTH);
    localparam int c_CNT_W    = $clog2(DEPTH + 1);
    localparam int c_STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0]    c_DEPTH_CNT  = c_CNT_W'(DEPTH);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);

    logic [4:0]            r_memReg  [DEPTH];
    logic [31:0]           r_memData [DEPTH];
    logic [c_PTR_W-1:0]    r_wrPtr;
    logic [c_PTR_W-1:0]    r_rdPtr;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_STARVE_W-1:0] r_starve;
    logic                  r_aluStall;
    logic                  r_err;
    logic                  r_regWrite;
    logic [4:0]            r_writeReg;
    logic [31:0]           r_writeData;

    logic                  w_memReady;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fifoNotEmpty;
    logic                  w_aluWin;
    logic                  w_fifoWin;
    logic [c_CNT_W-1:0]    w_countNext;
    logic [c_STARVE_W-1:0] w_starveNext;
    logic [4:0]            w_headReg;
    logic [31:0]           w_headData;
    logic [DEPTH-1:0]      w_slotHit;

    assign w_fifoNotEmpty = (r_count != '0);
    assign w_memReady     = (r_count < c_DEPTH_CNT);
    assign w_push         = bus.mem_valid && w_memReady;
    // A stalled ALU never wins; any result offered then is dropped and flagged.
    assign w_aluWin       = bus.alu_valid && !r_aluStall;
    assign w_fifoWin      = !w_aluWin && w_fifoNotEmpty;
    assign w_pop          = w_fifoWin;
    assign w_headReg      = r_memReg[r_rdPtr];
    assign w_headData     = r_memData[r_rdPtr];

    always_comb begin
        w_countNext = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_countNext = r_count + c_CNT_W'(1);
            2'b01:   w_countNext = r_count - c_CNT_W'(1);
            default: w_countNext = r_count;
        endcase
    end

    // The counter only runs while loads are waiting behind ALU traffic.
    always_comb begin
        w_starveNext = r_starve;
        if (!w_fifoNotEmpty || w_fifoWin) begin
            w_starveNext = '0;
        end else if (w_aluWin) begin
            w_starveNext = r_starve + c_STARVE_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_memReg[r_wrPtr]  <= bus.mem_reg;
            r_memData[r_wrPtr] <= bus.mem_data;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_starve    <= '0;
            r_aluStall  <= 1'b0;
            r_err       <= 1'b0;
            r_regWrite  <= 1'b0;
            r_writeReg  <= '0;
            r_writeData <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_PTR_W'(1);
            end
            r_count    <= w_countNext;
            r_starve   <= w_starveNext;
            r_aluStall <= (w_starveNext == c_STARVE_MAX);
            r_err      <= r_err | (bus.alu_valid & r_aluStall);

            // Writes to $0 still consume the slot but leave the port idle.
            if (w_aluWin) begin
                r_regWrite <= (bus.alu_reg != 5'd0);
                if (bus.alu_reg != 5'd0) begin
                    r_writeReg  <= bus.alu_reg;
                    r_writeData <= bus.alu_data;
                end
            end else if (w_fifoWin) begin
                r_regWrite <= (w_headReg != 5'd0);
                if (w_headReg != 5'd0) begin
                    r_writeReg  <= w_headReg;
                    r_writeData <= w_headData;
                end
            end else begin
                r_regWrite <= 1'b0;
            end
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    genvar j;
    generate
        for (j = 0; j < DEPTH; j++) begin : g_slot
            logic [c_PTR_W-1:0] w_offset;
            assign w_offset     = c_PTR_W'(j) - r_rdPtr;
            assign w_slotHit[j] = (c_CNT_W'(w_offset) < r_count) &&
                                  (r_memReg[j] == bus.query_reg);
        end
    endgenerate

    assign bus.pend_hit = (bus.query_reg != 5'd0) &&
                          ((|w_slotHit) || (r_regWrite && (r_writeReg == bus.query_reg)));

    assign bus.mem_ready     = w_memReady;
    assign bus.alu_stall     = r_aluStall;
    assign bus.err           = r_err;
    assign bus.RegWrite      = r_regWrite;
    assign bus.WriteRegister = r_writeReg;
    assign bus.WriteData     = r_writeData;

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_writeback
// Brief    : Self-checking bench for regfile_writeback against a queue model
// Revision : 1.0
// ============================================================================
module tb_regfile_writeback;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 3;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    logic Clk;
    logic Rst;
    regfile_writeback_if bus();

    regfile_writeback #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int nCmp = 0;
    int nBad = 0;

    // Reference model state
    ent_t        mq[$];
    logic        mRW;
    logic [4:0]  mWR;
    logic [31:0] mWD;
    logic        mStall;
    logic        mErr;
    int          mCtr;

    task automatic model_reset();
        mq.delete();
        mRW = 1'b0; mWR = '0; mWD = '0;
        mStall = 1'b0; mErr = 1'b0; mCtr = 0;
    endtask

    function automatic logic mPend(input logic [4:0] q);
        if (q == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].r == q) return 1'b1;
        return mRW && (mWR == q);
    endfunction

    // Advance one clock and apply the arbitration rules to the model.
    task automatic tick();
        ent_t e;
        bit   pushOk;
        bit   aluWins;
        @(posedge Clk);
        pushOk  = bus.mem_valid && (mq.size() < DEPTH);
        aluWins = bus.alu_valid && !mStall;
        if (bus.alu_valid && mStall) mErr = 1'b1;
        if (aluWins) begin
            mRW = (bus.alu_reg != 5'd0);
            if (mRW) begin mWR = bus.alu_reg; mWD = bus.alu_data; end
            mCtr = (mq.size() > 0) ? mCtr + 1 : 0;
        end else if (mq.size() > 0) begin
            e   = mq.pop_front();
            mRW = (e.r != 5'd0);
            if (mRW) begin mWR = e.r; mWD = e.d; end
            mCtr = 0;
        end else begin
            mRW  = 1'b0;
            mCtr = 0;
        end
        mStall = (mCtr == STARVE_LIMIT);
        if (pushOk) begin
            e.r = bus.mem_reg; e.d = bus.mem_data;
            mq.push_back(e);
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_reg = '0; bus.mem_data = '0;
    endtask

    task automatic drain();
        idle_inputs();
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        idle_inputs();
        bus.query_reg = '0;
        model_reset();
        #12;
        nCmp++; if (bus.RegWrite !== 1'b0) begin nBad++; $display("FAIL reset_regwrite got=%b exp=0", bus.RegWrite); end
        nCmp++; if (bus.WriteRegister !== 5'd0) begin nBad++; $display("FAIL reset_wreg got=%0d exp=0", bus.WriteRegister); end
        nCmp++; if (bus.WriteData !== 32'd0) begin nBad++; $display("FAIL reset_wdata got=%h exp=0", bus.WriteData); end
        nCmp++; if (bus.alu_stall !== 1'b0) begin nBad++; $display("FAIL reset_stall got=%b exp=0", bus.alu_stall); end
        nCmp++; if (bus.err !== 1'b0) begin nBad++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        nCmp++; if (bus.mem_ready !== 1'b1) begin nBad++; $display("FAIL reset_memready got=%b exp=1", bus.mem_ready); end
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic test_alu_single();
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd5; bus.alu_data = 32'h12345678;
        bus.query_reg = 5'd5;
        tick();
        nCmp++; if (bus.RegWrite !== 1'b1) begin nBad++; $display("FAIL alu_regwrite got=%b exp=1", bus.RegWrite); end
        nCmp++; if (bus.WriteRegister !== 5'd5) begin nBad++; $display("FAIL alu_wreg got=%0d exp=5", bus.WriteRegister); end
        nCmp++; if (bus.WriteData !== 32'h12345678) begin nBad++; $display("FAIL alu_wdata got=%h exp=12345678", bus.WriteData); end
        nCmp++; if (bus.pend_hit !== 1'b1) begin nBad++; $display("FAIL alu_pend got=%b exp=1", bus.pend_hit); end
        idle_inputs();
        tick();
        nCmp++; if (bus.RegWrite !== 1'b0) begin nBad++; $display("FAIL alu_idle_regwrite got=%b exp=0", bus.RegWrite); end
        nCmp++; if (bus.WriteRegister !== 5'd5) begin nBad++; $display("FAIL alu_idle_hold got=%0d exp=5", bus.WriteRegister); end
    endtask

    task automatic test_alu_zero();
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd0; bus.alu_data = 32'hFFFFFFFF;
        bus.query_reg = 5'd0;
        tick();
        idle_inputs();
        nCmp++; if (bus.RegWrite !== 1'b0) begin nBad++; $display("FAIL zero_regwrite got=%b exp=0", bus.RegWrite); end
        nCmp++; if (bus.pend_hit !== 1'b0) begin nBad++; $display("FAIL zero_pend got=%b exp=0", bus.pend_hit); end
    endtask

    // ALU writes to $0 keep the FIFO from draining so it fills up.
    task automatic test_fifo_fill();
        for (int i = 0; i < 4; i++) begin
            bus.alu_valid = 1'b1; bus.alu_reg = 5'd0; bus.alu_data = 32'h0;
            bus.mem_valid = 1'b1; bus.mem_reg = 5'(8 + i); bus.mem_data = 32'hA0 + 32'(i);
            tick();
            nCmp++; if (bus.mem_ready !== (i < 3)) begin nBad++; $display("FAIL fill_memready[%0d] got=%b exp=%b", i, bus.mem_ready, (i < 3)); end
        end
        nCmp++; if (bus.alu_stall !== 1'b1) begin nBad++; $display("FAIL fill_stall got=%b exp=1", bus.alu_stall); end
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            tick();
            nCmp++; if (bus.RegWrite !== 1'b1) begin nBad++; $display("FAIL fill_rw[%0d] got=%b exp=1", k, bus.RegWrite); end
            nCmp++; if (bus.WriteRegister !== 5'(8 + k)) begin nBad++; $display("FAIL fill_wreg[%0d] got=%0d exp=%0d", k, bus.WriteRegister, 8 + k); end
            nCmp++; if (bus.WriteData !== 32'hA0 + 32'(k)) begin nBad++; $display("FAIL fill_wdata[%0d] got=%h exp=%h", k, bus.WriteData, 32'hA0 + 32'(k)); end
            if (k == 0) begin
                nCmp++; if (bus.mem_ready !== 1'b1) begin nBad++; $display("FAIL fill_ready_after_pop got=%b exp=1", bus.mem_ready); end
                nCmp++; if (bus.alu_stall !== 1'b0) begin nBad++; $display("FAIL fill_stall_one_cycle got=%b exp=0", bus.alu_stall); end
            end
        end
        tick();
        nCmp++; if (bus.RegWrite !== 1'b0) begin nBad++; $display("FAIL fill_drained got=%b exp=0", bus.RegWrite); end
    endtask

    task automatic test_full_pushpop();
        logic [4:0] expQ[$];
        logic [4:0] gotQ[$];
        logic [4:0] nextReg;
        for (int i = 0; i < 4; i++) begin
            bus.alu_valid = 1'b1; bus.alu_reg = 5'd0;
            bus.mem_valid = 1'b1; bus.mem_reg = 5'(12 + i); bus.mem_data = $urandom;
            if (mq.size() < DEPTH) expQ.push_back(bus.mem_reg);
            tick();
        end
        bus.alu_valid = 1'b0;
        bus.query_reg = 5'd15;
        #1;
        nCmp++; if (bus.pend_hit !== 1'b1) begin nBad++; $display("FAIL pp_pend_queued got=%b exp=1", bus.pend_hit); end
        nextReg = 5'd16;
        for (int c = 0; c < 14; c++) begin
            bus.mem_valid = (c < 10); bus.mem_reg = nextReg; bus.mem_data = $urandom;
            if (bus.mem_valid && mq.size() < DEPTH) begin
                expQ.push_back(nextReg);
                nextReg = nextReg + 5'd1;
            end
            tick();
            if (bus.RegWrite === 1'b1) gotQ.push_back(bus.WriteRegister);
            nCmp++; if (bus.RegWrite !== mRW) begin nBad++; $display("FAIL pp_rw[%0d] got=%b exp=%b", c, bus.RegWrite, mRW); end
            if (mRW) begin
                nCmp++; if (bus.WriteData !== mWD) begin nBad++; $display("FAIL pp_wdata[%0d] got=%h exp=%h", c, bus.WriteData, mWD); end
            end
            nCmp++; if (bus.mem_ready !== (mq.size() < DEPTH)) begin nBad++; $display("FAIL pp_ready[%0d] got=%b exp=%b", c, bus.mem_ready, (mq.size() < DEPTH)); end
            nCmp++; if (bus.pend_hit !== mPend(bus.query_reg)) begin nBad++; $display("FAIL pp_pend[%0d] got=%b exp=%b", c, bus.pend_hit, mPend(bus.query_reg)); end
        end
        nCmp++; if (gotQ.size() != expQ.size()) begin nBad++; $display("FAIL pp_count got=%0d exp=%0d", gotQ.size(), expQ.size()); end
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
            nCmp++; if (gotQ[i] !== expQ[i]) begin nBad++; $display("FAIL pp_order[%0d] got=%0d exp=%0d", i, gotQ[i], expQ[i]); end
        end
        nCmp++; if (bus.pend_hit !== 1'b0) begin nBad++; $display("FAIL pp_pend_retired got=%b exp=0", bus.pend_hit); end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.alu_valid = ($urandom_range(0, 1) == 1) && !mStall;
            bus.alu_reg   = 5'($urandom_range(0, 31));
            bus.alu_data  = $urandom;
            bus.mem_valid = ($urandom_range(0, 2) != 0);
            bus.mem_reg   = 5'($urandom_range(0, 31));
            bus.mem_data  = $urandom;
            bus.query_reg = 5'($urandom_range(0, 31));
            tick();
            nCmp++; if (bus.RegWrite !== mRW) begin nBad++; $display("FAIL rnd_rw[%0d] got=%b exp=%b", c, bus.RegWrite, mRW); end
            if (mRW) begin
                nCmp++; if (bus.WriteRegister !== mWR || bus.WriteData !== mWD) begin nBad++; $display("FAIL rnd_write[%0d] got=%0d/%h exp=%0d/%h", c, bus.WriteRegister, bus.WriteData, mWR, mWD); end
            end
            nCmp++; if (bus.alu_stall !== mStall) begin nBad++; $display("FAIL rnd_stall[%0d] got=%b exp=%b", c, bus.alu_stall, mStall); end
            nCmp++; if (bus.mem_ready !== (mq.size() < DEPTH)) begin nBad++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", c, bus.mem_ready, (mq.size() < DEPTH)); end
            nCmp++; if (bus.pend_hit !== mPend(bus.query_reg)) begin nBad++; $display("FAIL rnd_pend[%0d] got=%b exp=%b", c, bus.pend_hit, mPend(bus.query_reg)); end
            nCmp++; if (bus.err !== mErr) begin nBad++; $display("FAIL rnd_err[%0d] got=%b exp=%b", c, bus.err, mErr); end
        end
        drain();
    endtask

    task automatic test_starvation();
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd20; bus.alu_data = 32'h20;
        bus.mem_valid = 1'b1; bus.mem_reg = 5'd9; bus.mem_data = 32'h99;
        tick();
        bus.mem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nCmp++; if (bus.alu_stall !== 1'b0) begin nBad++; $display("FAIL starve_early_stall[%0d] got=%b exp=0", i, bus.alu_stall); end
            bus.alu_reg = 5'(21 + i); bus.alu_data = 32'h21 + 32'(i);
            tick();
            nCmp++; if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'(21 + i)) begin nBad++; $display("FAIL starve_alu[%0d] got=%b/%0d exp=1/%0d", i, bus.RegWrite, bus.WriteRegister, 21 + i); end
        end
        nCmp++; if (bus.alu_stall !== 1'b1) begin nBad++; $display("FAIL starve_stall got=%b exp=1", bus.alu_stall); end
        bus.alu_reg = 5'd30;
        tick();
        nCmp++; if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'd9 || bus.WriteData !== 32'h99) begin nBad++; $display("FAIL starve_load got=%b/%0d/%h exp=1/9/99", bus.RegWrite, bus.WriteRegister, bus.WriteData); end
        nCmp++; if (bus.alu_stall !== 1'b0) begin nBad++; $display("FAIL starve_release got=%b exp=0", bus.alu_stall); end
        nCmp++; if (bus.err !== 1'b1) begin nBad++; $display("FAIL starve_err got=%b exp=1", bus.err); end
        drain();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            bus.alu_valid = 1'b1; bus.alu_reg = 5'd7; bus.alu_data = 32'h7;
            bus.mem_valid = 1'b1; bus.mem_reg = 5'(26 + i); bus.mem_data = $urandom;
            tick();
        end
        idle_inputs();
        bus.query_reg = 5'd27;
        nCmp++; if (bus.RegWrite !== 1'b1) begin nBad++; $display("FAIL arst_pre_rw got=%b exp=1", bus.RegWrite); end
        #3;
        Rst = 1'b1;
        model_reset();
        #1;
        nCmp++; if (bus.RegWrite !== 1'b0) begin nBad++; $display("FAIL arst_rw got=%b exp=0", bus.RegWrite); end
        nCmp++; if (bus.mem_ready !== 1'b1) begin nBad++; $display("FAIL arst_ready got=%b exp=1", bus.mem_ready); end
        nCmp++; if (bus.pend_hit !== 1'b0) begin nBad++; $display("FAIL arst_pend got=%b exp=0", bus.pend_hit); end
        nCmp++; if (bus.err !== 1'b0) begin nBad++; $display("FAIL arst_err got=%b exp=0", bus.err); end
        #2;
        Rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            nCmp++; if (bus.RegWrite !== 1'b0) begin nBad++; $display("FAIL arst_after[%0d] got=%b exp=0", i, bus.RegWrite); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired nCmp=%0d", nCmp);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_alu_single();
        test_alu_zero();
        test_fifo_fill();
        test_full_pushpop();
        test_random();
        test_starvation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
`default_nettype wire
